// File: rtl/trc_pkg.sv
// Shared TRC definitions: state encodings, event codes and one-hot state masks,
// plus the successor relation and mask helpers used by the event monitor.
package trc_pkg;

  typedef enum logic [2:0] {
    ST_START = 3'd0,
    ST_A     = 3'd1,
    ST_B     = 3'd2,
    ST_C     = 3'd3,
    ST_D     = 3'd4,
    ST_UNRES = 3'd7
  } trc_state_e;

  localparam int N_ST = 5;
  typedef logic [N_ST-1:0] trc_mask_t;

  localparam trc_mask_t M_NONE  = 5'b00000;
  localparam trc_mask_t M_START = 5'b00001;
  localparam trc_mask_t M_A     = 5'b00010;
  localparam trc_mask_t M_B     = 5'b00100;
  localparam trc_mask_t M_C     = 5'b01000;
  localparam trc_mask_t M_D     = 5'b10000;

  // *_M codes are the "managed" variants (mng = 1)
  localparam logic [3:0] EV_START_M = 4'b0000;
  localparam logic [3:0] EV_START   = 4'b0011;
  localparam logic [3:0] EV_A_M     = 4'b1010;
  localparam logic [3:0] EV_A       = 4'b0100;
  localparam logic [3:0] EV_B_M     = 4'b1011;
  localparam logic [3:0] EV_B       = 4'b0101;
  localparam logic [3:0] EV_C_M     = 4'b1100;
  localparam logic [3:0] EV_D_M     = 4'b1101;
  localparam logic [3:0] EV_CD      = 4'b0110;

  function automatic trc_mask_t succ_mask(input trc_mask_t cand);
    trc_mask_t s;
    s = M_NONE;
    if ((cand & M_START) != M_NONE) s = s | M_A | M_C;
    if ((cand & M_A)     != M_NONE) s = s | M_A | M_B;
    if ((cand & M_B)     != M_NONE) s = s | M_B | M_C;
    if ((cand & M_C)     != M_NONE) s = s | M_D;
    if ((cand & M_D)     != M_NONE) s = s | M_C | M_D;
    return s;
  endfunction

  function automatic trc_state_e mask_to_state(input trc_mask_t m);
    case (m)
      M_START: return ST_START;
      M_A:     return ST_A;
      M_B:     return ST_B;
      M_C:     return ST_C;
      M_D:     return ST_D;
      default: return ST_UNRES;
    endcase
  endfunction

  function automatic logic mask_amb(input trc_mask_t m);
    return (m & (m - 5'd1)) != M_NONE;
  endfunction

endpackage

// File: rtl/evnt_monitor_if.sv
// Event-in / decode-out bundle of the TRC event monitor.
interface evnt_monitor_if #(parameter int CNT_W = 8);
  logic             evnt_vld;
  logic [3:0]       evnt;
  logic             err_clr;
  logic             dec_vld;
  logic [2:0]       dec_state;
  logic             dec_mng;
  logic             dec_amb;
  logic             err;
  logic             err_sticky;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output evnt_vld, evnt, err_clr,
    input  dec_vld, dec_state, dec_mng, dec_amb, err, err_sticky, err_cnt
  );

  modport slave (
    input  evnt_vld, evnt, err_clr,
    output dec_vld, dec_state, dec_mng, dec_amb, err, err_sticky, err_cnt
  );
endinterface

// File: rtl/evnt_decode.sv
// Combinational map from a 4-bit TRC event code to its candidate state mask and mng flag.
module evnt_decode
  import trc_pkg::*;
(
  input  logic [3:0] i_evnt,
  output trc_mask_t  o_mask,
  output logic       o_mng
);

  always_comb begin
    o_mask = M_NONE;
    o_mng  = 1'b0;
    case (i_evnt)
      EV_START_M: begin o_mask = M_START;   o_mng = 1'b1; end
      EV_START:         o_mask = M_START;
      EV_A_M:     begin o_mask = M_A;       o_mng = 1'b1; end
      EV_A:             o_mask = M_A;
      EV_B_M:     begin o_mask = M_B;       o_mng = 1'b1; end
      EV_B:             o_mask = M_B;
      EV_C_M:     begin o_mask = M_C;       o_mng = 1'b1; end
      EV_D_M:     begin o_mask = M_D;       o_mng = 1'b1; end
      EV_CD:            o_mask = M_C | M_D;
      default:          o_mask = M_NONE;
    endcase
  end

endmodule

// File: rtl/evnt_monitor.sv
// Tracks the TRC generator state from its event stream and flags illegal codes/transitions.
// Define EVNT_MONITOR_ERRCNT_EN to build the saturating error counter; otherwise err_cnt is 0.
module evnt_monitor
  import trc_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          reset,
  evnt_monitor_if.slave bus
);

  trc_mask_t  w_map, w_succ, w_hit, w_nxt;
  logic       w_mng, w_err, w_err_ev;

  trc_mask_t  r_cand;
  logic       r_dec_vld, r_dec_mng, r_dec_amb, r_err, r_err_sticky;
  trc_state_e r_dec_state;

  evnt_decode u_decode (
    .i_evnt (bus.evnt),
    .o_mask (w_map),
    .o_mng  (w_mng)
  );

  // Unknown history accepts any legal code; a dead-end resyncs to the code's own mask.
  always_comb begin
    w_succ = succ_mask(r_cand);
    w_hit  = w_succ & w_map;
    w_nxt  = w_map;
    w_err  = 1'b0;
    if (r_cand == M_NONE) begin
      w_err = (w_map == M_NONE);
    end else if (w_hit != M_NONE) begin
      w_nxt = w_hit;
    end else begin
      w_err = 1'b1;
    end
  end

  assign w_err_ev = bus.evnt_vld & w_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cand       <= M_NONE;
      r_dec_vld    <= 1'b0;
      r_dec_state  <= ST_UNRES;
      r_dec_mng    <= 1'b0;
      r_dec_amb    <= 1'b0;
      r_err        <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_dec_vld <= bus.evnt_vld;
      r_err     <= w_err_ev;
      if (bus.evnt_vld) begin
        r_cand      <= w_nxt;
        r_dec_state <= mask_to_state(w_nxt);
        r_dec_mng   <= w_mng;
        r_dec_amb   <= mask_amb(w_nxt);
      end
      if (w_err_ev)         r_err_sticky <= 1'b1;
      else if (bus.err_clr) r_err_sticky <= 1'b0;
    end
  end

`ifdef EVNT_MONITOR_ERRCNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [CNT_W-1:0] r_err_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_cnt <= '0;
    end else if (bus.err_clr) begin
      r_err_cnt <= w_err_ev ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
    end else if (w_err_ev && (r_err_cnt != CNT_MAX)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign bus.err_cnt = r_err_cnt;
`else
  assign bus.err_cnt = {CNT_W{1'b0}};
`endif

  assign bus.dec_vld    = r_dec_vld;
  assign bus.dec_state  = r_dec_state;
  assign bus.dec_mng    = r_dec_mng;
  assign bus.dec_amb    = r_dec_amb;
  assign bus.err        = r_err;
  assign bus.err_sticky = r_err_sticky;

endmodule

// File: tb/tb_evnt_monitor.sv
// Bench for evnt_monitor: directed sequences plus random codes against a set-based reference model.
module tb_evnt_monitor;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = 255;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  evnt_monitor_if #(.CNT_W(CNT_W)) bus ();
  evnt_monitor #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: set of still-possible states (bit i = state i) and error bookkeeping
  bit [4:0] m_cand;
  int       m_state;
  bit       m_amb, m_mng, m_sticky;
  int       m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit [4:0] ref_map(input logic [3:0] c);
    bit [4:0] s;
    s = '0;
    case (c)
      4'h0, 4'h3: s[0] = 1'b1;
      4'hA, 4'h4: s[1] = 1'b1;
      4'hB, 4'h5: s[2] = 1'b1;
      4'hC:       s[3] = 1'b1;
      4'hD:       s[4] = 1'b1;
      4'h6:       begin s[3] = 1'b1; s[4] = 1'b1; end
      default:    s = '0;
    endcase
    return s;
  endfunction

  function automatic bit ref_mng(input logic [3:0] c);
    return c inside {4'h0, 4'hA, 4'hB, 4'hC, 4'hD};
  endfunction

  function automatic bit can_follow(input int s, input int t);
    case (s)
      0: return (t == 1) || (t == 3);
      1: return (t == 1) || (t == 2);
      2: return (t == 2) || (t == 3);
      3: return (t == 4);
      4: return (t == 3) || (t == 4);
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_cand = '0; m_state = 7; m_amb = 0; m_mng = 0; m_sticky = 0; m_cnt = 0;
  endtask

  task automatic model_step(input logic [3:0] c, input bit vld, input bit clr, output bit err);
    bit [4:0] mp, nx;
    int k, idx;
    err = 1'b0;
    if (vld) begin
      mp = ref_map(c);
      nx = '0;
      if (m_cand == '0) begin
        nx  = mp;
        err = (mp == '0);
      end else begin
        for (int t = 0; t < 5; t++)
          for (int s = 0; s < 5; s++)
            if (mp[t] && m_cand[s] && can_follow(s, t)) nx[t] = 1'b1;
        if (nx == '0) begin
          nx  = mp;
          err = 1'b1;
        end
      end
      m_cand = nx;
      k = 0; idx = 0;
      for (int i = 0; i < 5; i++) if (nx[i]) begin k++; idx = i; end
      m_state = (k == 1) ? idx : 7;
      m_amb   = (k > 1);
      m_mng   = ref_mng(c);
    end
    if (err)      m_sticky = 1'b1;
    else if (clr) m_sticky = 1'b0;
`ifdef EVNT_MONITOR_ERRCNT_EN
    if (clr)                       m_cnt = err ? 1 : 0;
    else if (err && m_cnt < CNT_MAX) m_cnt++;
`else
    m_cnt = 0;
`endif
  endtask

  task automatic step(input logic [3:0] c, input bit vld, input bit clr, input string tag);
    bit e;
    bus.evnt = c; bus.evnt_vld = vld; bus.err_clr = clr;
    @(posedge clk); #1;
    bus.evnt_vld = 1'b0; bus.err_clr = 1'b0;
    model_step(c, vld, clr, e);
    check({tag, ".vld"},    bus.dec_vld,    vld);
    check({tag, ".err"},    bus.err,        e);
    check({tag, ".state"},  bus.dec_state,  m_state);
    check({tag, ".amb"},    bus.dec_amb,    m_amb);
    check({tag, ".mng"},    bus.dec_mng,    m_mng);
    check({tag, ".sticky"}, bus.err_sticky, m_sticky);
    check({tag, ".cnt"},    bus.err_cnt,    m_cnt);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".vld"},    bus.dec_vld,    0);
    check({tag, ".state"},  bus.dec_state,  7);
    check({tag, ".mng"},    bus.dec_mng,    0);
    check({tag, ".amb"},    bus.dec_amb,    0);
    check({tag, ".err"},    bus.err,        0);
    check({tag, ".sticky"}, bus.err_sticky, 0);
    check({tag, ".cnt"},    bus.err_cnt,    0);
  endtask

  initial begin
    reset = 1'b1;
    bus.evnt = 4'h0; bus.evnt_vld = 1'b0; bus.err_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    @(negedge clk);
    reset = 1'b0;

    // Legal walk START, A, B, C, D
    step(4'h3, 1, 0, "walk0"); check("walk0.lit", bus.dec_state, 0);
    step(4'h4, 1, 0, "walk1"); check("walk1.lit", bus.dec_state, 1);
    step(4'h5, 1, 0, "walk2"); check("walk2.lit", bus.dec_state, 2);
    step(4'h6, 1, 0, "walk3"); check("walk3.lit", bus.dec_state, 3);
    step(4'h6, 1, 0, "walk4"); check("walk4.lit", bus.dec_state, 4);
    step(4'h0, 0, 0, "idle");

    // Ambiguity from D, then resolved by a D-only code
    step(4'h6, 1, 0, "amb0"); check("amb0.lit", bus.dec_amb, 1);
    step(4'hD, 1, 0, "amb1"); check("amb1.lit", bus.dec_state, 4);

    // Illegal code from A, then recovery from unknown
    step(4'h3, 1, 0, "ill0");
    step(4'h4, 1, 0, "ill1");
    step(4'h0, 0, 1, "ill.clr");
    step(4'h8, 1, 0, "ill2"); check("ill2.lit", bus.dec_state, 7);
    check("ill2.errlit", bus.err, 1);
    step(4'h4, 1, 0, "ill3"); check("ill3.lit", bus.dec_state, 1);

    // Illegal transition START -> B resyncs to B
    step(4'h8, 1, 0, "tr0");
    step(4'h3, 1, 0, "tr1");
    step(4'h5, 1, 0, "tr2"); check("tr2.lit", bus.dec_state, 2);
    check("tr2.stlit", bus.err_sticky, 1);

    // Random stream
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0), "rnd");
    end

    // Counter saturation, then clear coinciding with an error
    step(4'h0, 0, 1, "sat.clr");
    for (int i = 0; i < 300; i++) step(4'h8, 1, 0, "sat");
`ifdef EVNT_MONITOR_ERRCNT_EN
    check("sat.lit", bus.err_cnt, 255);
`else
    check("sat.lit", bus.err_cnt, 0);
`endif
    step(4'h8, 1, 1, "satclr");
`ifdef EVNT_MONITOR_ERRCNT_EN
    check("satclr.lit", bus.err_cnt, 1);
`else
    check("satclr.lit", bus.err_cnt, 0);
`endif
    check("satclr.stlit", bus.err_sticky, 1);

    // Asynchronous reset between edges
    step(4'h3, 1, 0, "ar0");
    step(4'h4, 1, 0, "ar1");
    bus.evnt = 4'h5; bus.evnt_vld = 1'b1;
    #2 reset = 1'b1;
    #1 check_reset_vals("arst");
    model_reset();
    #2 reset = 1'b0;
    bus.evnt_vld = 1'b0;
    step(4'h5, 1, 0, "ar2"); check("ar2.lit", bus.dec_state, 2);
    check("ar2.errlit", bus.err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/evnt_monitor.md
EVNT_MONITOR -- requirements
Module: evnt_monitor

Interface
REQ-001 Parameter: CNT_W, default 8, width of the error counter.
REQ-002 Port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: evnt_vld  input  1  marks one producer step; evnt is sampled only when high.
REQ-005 Port: evnt  input  4  event code emitted by the TRC event generator.
REQ-006 Port: err_clr  input  1  clears err_sticky and err_cnt.
REQ-007 Port: dec_vld  output  1  decoded result valid, one pulse per sampled evnt.
REQ-008 Port: dec_state  output  3  reconstructed state (START=0, A=1, B=2, C=3, D=4), 7 = unresolved.
REQ-009 Port: dec_mng  output  1  decoded mng flag of the sampled code.
REQ-010 Port: dec_amb  output  1  high when more than one state is still possible.
REQ-011 Port: err  output  1  error pulse, aligned with dec_vld.
REQ-012 Port: err_sticky  output  1  latched error flag.
REQ-013 Port: err_cnt  output  CNT_W  saturating error count.

Function
REQ-014 The code map SHALL be: 0000/0011 -> {START}, 1010/0100 -> {A}, 1011/0101 -> {B}, 1100 -> {C}, 1101 -> {D}, 0110 -> {C,D}, all other codes -> {} (illegal).
REQ-015 dec_mng SHALL be 1 for 0000, 1010, 1011, 1100 and 1101, and 0 for all other codes.
REQ-016 Successor sets SHALL be: START -> {A,C}, A -> {A,B}, B -> {B,C}, C -> {D}, D -> {C,D}.
REQ-017 The block SHALL hold a 5-bit one-hot candidate mask cand; cand = 0 means unknown.
REQ-018 On evnt_vld with cand = 0: next cand = map(evnt), and err fires only if that map is empty.
REQ-019 On evnt_vld with cand != 0: next cand = succ(cand) AND map(evnt).
- If that result is empty, err fires and cand resyncs to map(evnt), which may itself be 0.
REQ-020 All outputs SHALL be registered; dec_vld and err SHALL follow the sampling edge by exactly 1 cycle.
REQ-021 With evnt_vld low, cand SHALL hold and dec_vld/err SHALL be 0; dec_state/dec_mng/dec_amb hold.
REQ-022 dec_state SHALL be the index of the set bit when cand is one-hot, else 7.
- dec_amb = popcount(cand) > 1.
REQ-023 err_sticky SHALL set on err and clear on err_clr; if both occur in one cycle, set wins.
REQ-024 err_cnt SHALL increment on err and saturate at 2^CNT_W-1.
- err_clr zeroes it; with err and err_clr in one cycle it becomes 1.

Reset
REQ-025 While reset is high: cand = 0, dec_vld = 0, dec_state = 7, dec_mng = 0, dec_amb = 0, err = 0, err_sticky = 0, err_cnt = 0.
REQ-026 Assertion of reset mid-stream SHALL take effect immediately, regardless of clk.

Configuration
REQ-027 Macro EVNT_MONITOR_ERRCNT_EN SHALL control the error counter.
- Defined: err_cnt behaves per REQ-024.
- Undefined: no counter register exists and err_cnt is tied to 0; err and err_sticky are unaffected.

Structure
REQ-028 Package trc_pkg SHALL hold the state encodings, the event code constants and the one-hot mask constants shared with the event generator.
REQ-029 Sub-module evnt_decode (combinational) SHALL map evnt to {mask, mng}; evnt_monitor holds all state.

Verification
REQ-030 After reset, stream 0011,0100,0101,0110,0110:
- dec_state 0,1,2,3,4; dec_mng 0 throughout; err never set.
REQ-031 From D, stream 0110 then 1101:
- First: dec_state 7, dec_amb 1.
- Second: dec_state 4, dec_amb 0, dec_mng 1, no err.
REQ-032 Illegal code 1000 from A:
- err pulse, err_cnt 1, dec_state 7.
- Next 0100 gives dec_state 1 with no err.
REQ-033 Illegal transition, 0011 then 0101:
- err pulse, err_sticky 1, dec_state 2 (resync to B).
REQ-034 300 consecutive illegal codes (macro defined) give err_cnt 255.
- Then err_clr together with err gives err_cnt 1, err_sticky 1.
- Macro undefined: err_cnt stays 0.
REQ-035 Reset asserted between clock edges mid-stream:
- All outputs take REQ-025 values before the next edge.
- First code after release is accepted without err.
